div_issue_ctrl: RTL

Request/response front end for the pipelined single-precision divider. It accepts divide requests over a valid/ready handshake, holds the operands stable on the divider inputs, waits for the divider's fixed latency and captures the result, error and overflow flags. It returns them with the request tag over a valid/ready response channel and keeps sticky exception flags for the FPU status path. The divider's exception logic reads the live operands at its output stage, so only one operation is in flight at a time.

---
 rtl/div_issue_ctrl_if.sv | 34 +++
 rtl/div_issue_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle for the divider front end.
// slave = the issue controller, master = the requesting unit.
interface div_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_rm;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_error;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_rm, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_error,
    input  rsp_overflow, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_a, req_b, req_rm, req_tag,
    output req_ready,
    output rsp_valid, rsp_result, rsp_error,
    output rsp_overflow, rsp_tag,
    input  rsp_ready
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Single-in-flight issue/capture front end for the pipelined divider.
// Holds operands for LATENCY edges, then returns result with its tag.
module div_issue_ctrl #(
  parameter int LATENCY = 6,
  parameter int TAG_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  div_issue_ctrl_if.slave bus,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [1:0]  div_rm,
  input  logic [31:0] div_result,
  input  logic        div_error,
  input  logic        div_overflow,
  output logic        sticky_error,
  output logic        sticky_overflow,
  input  logic        sticky_clr,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [5:0] CNT_INIT = 6'(LATENCY - 1);

  state_t           r_state;
  state_t           w_nxt;
  logic [5:0]       r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [1:0]       r_rm;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_res;
  logic             r_err;
  logic             r_ovf;
  logic             r_st_err;
  logic             r_st_ovf;
  logic [15:0]      r_ops;
  logic             w_issue;
  logic             w_cap;
  logic             w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_issue = 1'b0;
    w_cap   = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_issue = 1'b1;
          w_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == 6'd0) begin
          w_cap = 1'b1;
          w_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_done = 1'b1;
          w_nxt  = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_rm  <= '0;
      r_tag <= '0;
      r_res <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
      r_ops <= '0;
    end else begin
      if (w_issue) begin
        r_a   <= bus.req_a;
        r_b   <= bus.req_b;
        r_rm  <= bus.req_rm;
        r_tag <= bus.req_tag;
        r_cnt <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 6'd0) begin
        r_cnt <= r_cnt - 6'd1;
      end
      if (w_cap) begin
        r_res <= div_result;
        r_err <= div_error;
        r_ovf <= div_overflow;
      end
      if (w_done) r_ops <= r_ops + 16'd1;
    end
  end

  // A flag being set on the capture edge beats a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_err <= 1'b0;
      r_st_ovf <= 1'b0;
    end else if (sticky_clr) begin
      r_st_err <= w_cap & div_error;
      r_st_ovf <= w_cap & div_overflow;
    end else begin
      r_st_err <= r_st_err | (w_cap & div_error);
      r_st_ovf <= r_st_ovf | (w_cap & div_overflow);
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.rsp_valid    = (r_state == RESP);
  assign bus.rsp_result   = r_res;
  assign bus.rsp_error    = r_err;
  assign bus.rsp_overflow = r_ovf;
  assign bus.rsp_tag      = r_tag;
  assign div_a            = r_a;
  assign div_b            = r_b;
  assign div_rm           = r_rm;
  assign sticky_error     = r_st_err;
  assign sticky_overflow  = r_st_ovf;
  assign busy             = (r_state != IDLE);
  assign ops_done         = r_ops;

endmodule
